// File: rtl/second_cnn_pkg.sv
// second_cnn_pkg: shared state encoding and default geometry for the second CNN stage sequencer.
package second_cnn_pkg;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;
  localparam int WIDTH    = 8;
  localparam int IMG_W    = 12;
  localparam int IMG_H    = 12;
  localparam int K        = 5;
  localparam int PIPE_LAT = 4;
  localparam int OUT_W    = IMG_W - K + 1;
  localparam int OUT_H    = IMG_H - K + 1;
endpackage

// File: rtl/second_cnn_ctrl_valid_delay_line.sv
// valid_delay_line: DEPTH-stage 1-bit shift register with async active-low clear.
module valid_delay_line #(
  parameter int DEPTH = second_cnn_pkg::PIPE_LAT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [DEPTH-1:0] sr_q, sr_d;
  always_comb sr_d = DEPTH'({sr_q, d});
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr_q <= '0;
    else sr_q <= sr_d;
  end
  assign q = sr_q[DEPTH-1];
endmodule

// File: rtl/second_cnn_ctrl.sv
// second_cnn_ctrl: raster-stream sequencer feeding the Second_CNN core and tracking its result positions.
module second_cnn_ctrl
  import second_cnn_pkg::*;
#(
  parameter int WIDTH    = second_cnn_pkg::WIDTH,
  parameter int IMG_W    = second_cnn_pkg::IMG_W,
  parameter int IMG_H    = second_cnn_pkg::IMG_H,
  parameter int K        = second_cnn_pkg::K,
  parameter int PIPE_LAT = second_cnn_pkg::PIPE_LAT
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [WIDTH-1:0]                s_data,
  input  logic                            s_valid,
  output logic                            s_ready,
  output logic [WIDTH-1:0]                core_din,
  output logic                            core_din_valid,
  output logic                            core_cal_valid,
  output logic                            out_valid,
  output logic [$clog2(IMG_H-K+1)-1:0]    out_row,
  output logic [$clog2(IMG_W-K+1)-1:0]    out_col,
  output logic                            busy,
  output logic                            done
);
  localparam int RW  = $clog2(IMG_H);
  localparam int CW  = $clog2(IMG_W);
  localparam int ORW = $clog2(IMG_H - K + 1);
  localparam int OCW = $clog2(IMG_W - K + 1);
  localparam int DW  = $clog2(PIPE_LAT + 1);
  state_t           state_q, state_d;
  logic [RW-1:0]    row_q, row_d;
  logic [CW-1:0]    col_q, col_d;
  logic [ORW-1:0]   orow_q, orow_d;
  logic [OCW-1:0]   ocol_q, ocol_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic             dv_q, dv_d, cv_q, cv_d;
  logic             row_last, col_last, ocol_last;
  assign row_last  = row_q == RW'(IMG_H - 1);
  assign col_last  = col_q == CW'(IMG_W - 1);
  assign ocol_last = ocol_q == OCW'(IMG_W - K);
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    orow_d  = orow_q;
    ocol_d  = ocol_q;
    drain_d = drain_q;
    din_d   = din_q;
    dv_d    = 1'b0;
    cv_d    = 1'b0;
    if (out_valid) begin
      ocol_d = ocol_last ? '0 : ocol_q + 1'b1;
      if (ocol_last) orow_d = (orow_q == ORW'(IMG_H - K)) ? '0 : orow_q + 1'b1;
    end
    case (state_q)
      IDLE: if (start) begin
        state_d = STREAM;
        row_d   = '0;
        col_d   = '0;
        orow_d  = '0;
        ocol_d  = '0;
        drain_d = '0;
      end
      STREAM: if (s_valid) begin
        din_d = s_data;
        dv_d  = 1'b1;
        cv_d  = (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));
        col_d = col_last ? '0 : col_q + 1'b1;
        if (col_last) row_d = row_last ? '0 : row_q + 1'b1;
        if (row_last && col_last) state_d = DRAIN;
      end
      // Extra DRAIN cycle lets the final result surface before done pulses.
      DRAIN: if (drain_q == DW'(PIPE_LAT)) state_d = DONE;
             else drain_d = drain_q + 1'b1;
      DONE: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      orow_q  <= '0;
      ocol_q  <= '0;
      drain_q <= '0;
      din_q   <= '0;
      dv_q    <= 1'b0;
      cv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      orow_q  <= orow_d;
      ocol_q  <= ocol_d;
      drain_q <= drain_d;
      din_q   <= din_d;
      dv_q    <= dv_d;
      cv_q    <= cv_d;
    end
  end
  valid_delay_line #(.DEPTH(PIPE_LAT)) u_out_valid (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (cv_q),
    .q    (out_valid)
  );
  assign s_ready        = state_q == STREAM;
  assign busy           = state_q != IDLE;
  assign done           = state_q == DONE;
  assign core_din       = din_q;
  assign core_din_valid = dv_q;
  assign core_cal_valid = cv_q;
  assign out_row        = orow_q;
  assign out_col        = ocol_q;
endmodule

// File: tb/tb_second_cnn_ctrl.sv
// tb_second_cnn_ctrl: directed frame scenarios with a per-beat monitor for second_cnn_ctrl.
module tb_second_cnn_ctrl;
  localparam int W = 12, H = 12, K = 5, PL = 4, N = W * H, OW = W - K + 1, OH = H - K + 1;
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic s_ready, core_din_valid, core_cal_valid, out_valid, busy, done;
  logic [7:0] core_din;
  logic [2:0] out_row, out_col;
  int checks = 0, errors = 0, cyc = 0;
  int dv_cnt, cal_cnt, first_cal, ov_cnt, done_cnt, done_cyc, last_ov_cyc;
  int last_r, last_c, first_r, first_c, sent, last_acc;
  logic [7:0] first_din, prev_din;
  logic [7:0] exp_pix [N];
  typedef struct {
    int mode;
    int exp_dv;
    int exp_cal;
    int exp_first;
    int exp_ov;
    int exp_lr;
    int exp_lc;
    int exp_done_lat;
  } vec_t;
  vec_t tbl [4];

  second_cnn_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .core_din      (core_din),
    .core_din_valid(core_din_valid),
    .core_cal_valid(core_cal_valid),
    .out_valid     (out_valid),
    .out_row       (out_row),
    .out_col       (out_col),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] pix(input int i);
    return i == 0 ? 8'h80 : i == 1 ? 8'h7f : 8'(i * 29 + 3);
  endfunction

  always @(negedge clk) begin
    if (!rst_n) prev_din = 8'h00;
    else begin
      if (core_din_valid) begin
        if (dv_cnt == 0) first_din = core_din;
        if (dv_cnt < N) check("din", int'(core_din), int'(exp_pix[dv_cnt]));
        check("cal_pattern", int'(core_cal_valid), int'((dv_cnt / W >= K - 1) && (dv_cnt % W >= K - 1)));
        if (core_cal_valid) begin
          if (cal_cnt == 0) first_cal = dv_cnt;
          cal_cnt++;
        end
        dv_cnt++;
        prev_din = core_din;
      end else begin
        check("cal_without_din", int'(core_cal_valid), 0);
        check("din_hold", int'(core_din), int'(prev_din));
      end
      if (out_valid) begin
        check("out_row_seq", int'(out_row), (ov_cnt / OW) % OH);
        check("out_col_seq", int'(out_col), ov_cnt % OW);
        if (ov_cnt == 0) begin
          first_r = out_row;
          first_c = out_col;
        end
        last_r = out_row;
        last_c = out_col;
        last_ov_cyc = cyc;
        ov_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic run_frame(input vec_t v, input int abort_at);
    int k;
    bit seen;
    @(negedge clk);
    check("idle_busy", int'(busy), 0);
    check("idle_done", int'(done), 0);
    dv_cnt = 0; cal_cnt = 0; first_cal = -1; ov_cnt = 0; done_cnt = 0;
    done_cyc = 0; last_ov_cyc = 0; last_r = -1; last_c = -1; first_r = -1; first_c = -1;
    sent = 0; last_acc = 0;
    start = 1'b1;
    check("ready_in_idle", int'(s_ready), 0);
    @(negedge clk);
    start = 1'b0;
    check("ready_after_start", int'(s_ready), 1);
    check("busy_after_start", int'(busy), 1);
    k = 0;
    while (sent < N && k < 2000) begin
      bit vv;
      vv = v.mode == 1 ? (k % 2 == 0) : v.mode == 2 ? (k % 3 == 0) : 1'b1;
      start = (v.mode == 3 && k == 30);
      s_valid = vv;
      s_data = vv ? pix(sent) : 8'($urandom);
      if (abort_at > 0 && sent == abort_at) begin
        s_valid = 1'b0;
        start = 1'b0;
        return;
      end
      if (vv && s_ready) begin
        exp_pix[sent] = s_data;
        last_acc = cyc;
        sent++;
      end
      k++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    seen = 1'b0;
    for (int j = 0; j < 40 && !seen; j++) begin
      if (done) seen = 1'b1;
      else begin
        start = (v.mode == 3 && j == 2);
        @(negedge clk);
      end
    end
    start = 1'b0;
    check("done_seen", int'(seen), 1);
    #1;
    check("din_valid_count", dv_cnt, v.exp_dv);
    check("cal_valid_count", cal_cnt, v.exp_cal);
    check("first_cal_index", first_cal, v.exp_first);
    check("first_din", int'(first_din), 8'h80);
    check("out_valid_count", ov_cnt, v.exp_ov);
    check("first_out_row", first_r, 0);
    check("first_out_col", first_c, 0);
    check("last_out_row", last_r, v.exp_lr);
    check("last_out_col", last_c, v.exp_lc);
    check("done_count", done_cnt, 1);
    check("done_latency", done_cyc - last_acc, v.exp_done_lat);
    check("last_out_latency", last_ov_cyc - last_acc, v.exp_done_lat - 1);
  endtask

  initial begin
    tbl[0] = '{0, N, OW * OH, (K - 1) * W + K - 1, OW * OH, OH - 1, OW - 1, PL + 2};
    tbl[1] = '{1, N, OW * OH, (K - 1) * W + K - 1, OW * OH, OH - 1, OW - 1, PL + 2};
    tbl[2] = '{2, N, OW * OH, (K - 1) * W + K - 1, OW * OH, OH - 1, OW - 1, PL + 2};
    tbl[3] = '{3, N, OW * OH, (K - 1) * W + K - 1, OW * OH, OH - 1, OW - 1, PL + 2};
    #2 rst_n = 1'b0;
    #1;
    check("reset_outputs", int'({s_ready, core_din, core_din_valid, core_cal_valid, out_valid, out_row, out_col, done}), 0);
    check("reset_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) run_frame(tbl[i], 0);
    run_frame(tbl[0], 0);
    run_frame(tbl[0], 0);
    run_frame(tbl[0], 71);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midframe_reset_outputs", int'({s_ready, core_din, core_din_valid, core_cal_valid, out_valid, out_row, out_col, done}), 0);
    check("midframe_reset_busy", int'(busy), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(tbl[0], 0);
    repeat (3) @(negedge clk);
    check("final_idle_busy", int'(busy), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
